rr_stage: RTL and testbench
===========================

// Module: rr_stage
// PURPOSE
//  Register-read stage between the id_rr pipeline register and EX. Reads the 8x32 architectural
//  register file, tracks in-flight writes with a per-register scoreboard, and stalls upstream on
//  RAW or saturation hazards. Registers operands plus pass-through fields into its RR/EX output register.
// PARAMETERS
//  MAX_INFLIGHT  3  max outstanding writes per register; pending counter width = $clog2(MAX_INFLIGHT+1)
// PORTS
//  clk              in   1   clock, rising edge
//  rst              in   1   synchronous reset, active-high
//  stall_in         in   1   EX cannot accept; hold RR/EX register
//  flush            in   1   discard incoming instr; clear RR/EX register
//  valid_in         in   1   instr from id_rr register is valid
//  pc_in            in   32  instruction PC
//  instr_length_in  in   3   instruction length in bytes
//  ctrl_in          in   7   [0]=reg_write [1]=use_src1 [2]=use_src2 [6:3]=alu_op
//  dst_idx_in       in   3   destination register
//  src1_idx_in      in   3   source 1 register
//  src2_idx_in      in   3   source 2 register
//  imm_in           in   32  immediate
//  wb_valid         in   1   writeback this cycle
//  wb_idx           in   3   writeback register
//  wb_data          in   32  writeback value
//  stall_out        out  1   to id_rr register: hold (combinational)
//  valid_out, pc_out[32], instr_length_out[3], ctrl_out[7], dst_idx_out[3], imm_out[32]  out  registered pass-through
//  src1_val_out     out  32  registered source 1 operand
//  src2_val_out     out  32  registered source 2 operand
// BEHAVIOUR
//  - Reset: all outputs 0, all 8 registers 0, all pending counters 0. Reset has priority over flush and stall_in.
//  - Effective pending: ep[r] = pend[r] - (wb_valid && wb_idx==r).
//  - hazard = valid_in && ((use_src1 && ep[src1]!=0) || (use_src2 && ep[src2]!=0)
//    || (reg_write && ep[dst]==MAX_INFLIGHT)).
//  - stall_out = stall_in || hazard.
//  - Issue = valid_in && !hazard && !stall_in && !flush. On issue, the RR/EX register captures all fields
//    next edge (latency 1) and increments pend[dst] if reg_write.
//  - Hazard without stall_in or flush: RR/EX register loads a bubble (valid_out=0, all fields 0).
//  - stall_in without flush: RR/EX register and scoreboard increments frozen. Writebacks still apply.
//  - flush: RR/EX register cleared to 0 next edge, incoming instr not issued. If flush && stall_in
//    && valid_out && ctrl_out[0], the held instr is cancelled and pend[dst_idx_out] is decremented.
//  - Writeback: regfile[wb_idx] <= wb_data and pend[wb_idx] decremented every wb_valid cycle,
//    regardless of stall or flush. A write with pend==0 is a protocol error: counter holds at 0.
//  - Same-cycle write-through: a source index equal to wb_idx reads wb_data.
//  - Same register incremented (issue) and decremented (wb) in one cycle: net unchanged.
//  - Counter never exceeds MAX_INFLIGHT, guaranteed by the saturation hazard term.
// CONFIGURATION
//  RR_R0_ZERO_EN defined: r0 always reads 0. Writes to r0 are ignored. r0 is never pending,
//    never causes a hazard, and issue with dst=0 does not increment.
//  RR_R0_ZERO_EN undefined: r0 is an ordinary register.
// STRUCTURE
//  Package rr_pkg: ctrl bit indices (CTRL_REG_WRITE=0, CTRL_USE_SRC1=1, CTRL_USE_SRC2=2,
//  CTRL_ALU_OP msb/lsb), NUM_REGS=8, REG_IDX_W=3, DATA_W=32.
//  Sub-module rr_scoreboard holds the pending counters, computes ep[]/hazard, and applies
//  inc/dec/cancel. Regfile and RR/EX register live in rr_stage.
// TESTING
//  1. rst=1 one cycle -> valid_out=0, pc_out=0, src1_val_out=0, stall_out=0.
//  2. wb r1=0x11 then issue pc=0x100, src1=1, use_src1 -> next cycle src1_val_out=0x11, pc_out=0x100, valid_out=1.
//  3. Issue write r2, then reader of r2 -> stall_out=1, bubble valid_out=0. wb r2=0xAB that cycle
//     -> stall drops same cycle; reader issues with src2_val_out=0xAB.
//  4. Four issues writing r3 with no wb (MAX_INFLIGHT=3) -> 4th stalls on saturation; one wb r3 -> 4th issues.
//  5. stall_in=1 with valid_in, pc_in=0xDEADBEEF -> outputs hold old values, pend unchanged.
//     Then flush -> all outputs 0 next cycle.
//  6. flush && stall_in while held instr writes r4 -> pend[r4] back to 0; later reader of r4 does not stall.

Source files
------------

// File: rtl/rr_pkg.sv
// Shared definitions for the register-read stage.
//  - Architectural register file geometry (NUM_REGS, REG_IDX_W, DATA_W).
//  - Bit positions inside the 7-bit control word carried with each instruction.
//  - rrex_t: contents of the RR/EX pipeline register.
package rr_pkg;

    localparam int NUM_REGS  = 8;
    localparam int REG_IDX_W = 3;
    localparam int DATA_W    = 32;
    localparam int PC_W      = 32;
    localparam int LEN_W     = 3;
    localparam int CTRL_W    = 7;

    // Control word layout
    localparam int CTRL_REG_WRITE  = 0;
    localparam int CTRL_USE_SRC1   = 1;
    localparam int CTRL_USE_SRC2   = 2;
    localparam int CTRL_ALU_OP_LSB = 3;
    localparam int CTRL_ALU_OP_MSB = 6;

    typedef struct packed {
        logic                 valid;
        logic [PC_W-1:0]      pc;
        logic [LEN_W-1:0]     len;
        logic [CTRL_W-1:0]    ctrl;
        logic [REG_IDX_W-1:0] dst;
        logic [DATA_W-1:0]    imm;
        logic [DATA_W-1:0]    src1_val;
        logic [DATA_W-1:0]    src2_val;
    } rrex_t;

endpackage

// File: rtl/rr_scoreboard.sv
// Per-register in-flight write tracker for the register-read stage.
// Optional feature macro: RR_R0_ZERO_EN (r0 is never tracked as pending).
//
// Ports:
//  clk, rst             clock, synchronous active-high reset
//  valid_in             incoming instruction is valid
//  use_src1/use_src2    incoming instruction reads src1/src2
//  reg_write            incoming instruction writes dst
//  src1_idx/src2_idx    incoming source indices
//  dst_idx              incoming destination index
//  inc_en/inc_idx       an instruction issued that writes inc_idx
//  wb_valid/wb_idx      writeback retiring one in-flight write of wb_idx
//  cancel/cancel_idx    a held instruction writing cancel_idx was flushed
//  hazard               incoming instruction must not issue this cycle
module rr_scoreboard
    import rr_pkg::*;
#(
    parameter int MAX_INFLIGHT = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_in,
    input  logic                 use_src1,
    input  logic                 use_src2,
    input  logic                 reg_write,
    input  logic [REG_IDX_W-1:0] src1_idx,
    input  logic [REG_IDX_W-1:0] src2_idx,
    input  logic [REG_IDX_W-1:0] dst_idx,
    input  logic                 inc_en,
    input  logic [REG_IDX_W-1:0] inc_idx,
    input  logic                 wb_valid,
    input  logic [REG_IDX_W-1:0] wb_idx,
    input  logic                 cancel,
    input  logic [REG_IDX_W-1:0] cancel_idx,
    output logic                 hazard
);

    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

    logic [CNT_W-1:0] pend      [NUM_REGS];
    logic [CNT_W-1:0] pend_next [NUM_REGS];
    logic [CNT_W-1:0] ep        [NUM_REGS];
    logic             inc_ok;
    int               cnt_tmp;

`ifdef RR_R0_ZERO_EN
    // r0 is hard-wired, so its counter never leaves zero.
    assign inc_ok = inc_en && (inc_idx != '0);
`else
    assign inc_ok = inc_en;
`endif

    // Effective pending: a writeback landing this cycle already satisfies
    // one outstanding write. A writeback to an idle register stays at zero.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            ep[r] = pend[r];
            if (wb_valid && wb_idx == REG_IDX_W'(r) && pend[r] != '0)
                ep[r] = pend[r] - CNT_W'(1);
        end
    end

    assign hazard = valid_in &&
                    ((use_src1  && ep[src1_idx] != '0) ||
                     (use_src2  && ep[src2_idx] != '0) ||
                     (reg_write && ep[dst_idx] == CNT_W'(MAX_INFLIGHT)));

    // Increment, writeback and cancel combine arithmetically so that a
    // same-register inc + dec nets to no change; the result floors at 0.
    always_comb begin
        cnt_tmp = 0;
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_tmp = int'(pend[r]);
            if (inc_ok && inc_idx == REG_IDX_W'(r))
                cnt_tmp = cnt_tmp + 1;
            if (wb_valid && wb_idx == REG_IDX_W'(r))
                cnt_tmp = cnt_tmp - 1;
            if (cancel && cancel_idx == REG_IDX_W'(r))
                cnt_tmp = cnt_tmp - 1;
            if (cnt_tmp < 0)
                cnt_tmp = 0;
            if (cnt_tmp > MAX_INFLIGHT)
                cnt_tmp = MAX_INFLIGHT;
            pend_next[r] = CNT_W'(cnt_tmp);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) pend[r] <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) pend[r] <= pend_next[r];
        end
    end

endmodule

// File: rtl/rr_stage.sv
// Register-read stage between the id_rr pipeline register and EX.
// Reads the 8x32 register file (with same-cycle writeback bypass), stalls
// upstream on RAW / saturation hazards, and loads the RR/EX register.
// Optional feature macro: RR_R0_ZERO_EN (r0 reads 0, ignores writes, never pending).
//
// Handshake: an instruction presented with valid_in is consumed on a rising
// edge where stall_out is low and flush is low; while stall_out is high the
// id_rr register must hold it unchanged. stall_in from EX freezes the RR/EX
// register; flush clears it (and cancels a held writer if also stalled).
//
// Ports:
//  clk, rst                     clock, synchronous active-high reset
//  stall_in, flush              EX back-pressure, pipeline flush
//  valid_in, pc_in, instr_length_in, ctrl_in, dst_idx_in,
//  src1_idx_in, src2_idx_in, imm_in      incoming instruction
//  wb_valid, wb_idx, wb_data    writeback port
//  stall_out                    combinational hold to id_rr
//  valid_out ... src2_val_out   registered RR/EX outputs
module rr_stage
    import rr_pkg::*;
#(
    parameter int MAX_INFLIGHT = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall_in,
    input  logic                 flush,
    input  logic                 valid_in,
    input  logic [PC_W-1:0]      pc_in,
    input  logic [LEN_W-1:0]     instr_length_in,
    input  logic [CTRL_W-1:0]    ctrl_in,
    input  logic [REG_IDX_W-1:0] dst_idx_in,
    input  logic [REG_IDX_W-1:0] src1_idx_in,
    input  logic [REG_IDX_W-1:0] src2_idx_in,
    input  logic [DATA_W-1:0]    imm_in,
    input  logic                 wb_valid,
    input  logic [REG_IDX_W-1:0] wb_idx,
    input  logic [DATA_W-1:0]    wb_data,
    output logic                 stall_out,
    output logic                 valid_out,
    output logic [PC_W-1:0]      pc_out,
    output logic [LEN_W-1:0]     instr_length_out,
    output logic [CTRL_W-1:0]    ctrl_out,
    output logic [REG_IDX_W-1:0] dst_idx_out,
    output logic [DATA_W-1:0]    imm_out,
    output logic [DATA_W-1:0]    src1_val_out,
    output logic [DATA_W-1:0]    src2_val_out
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] src1_val;
    logic [DATA_W-1:0] src2_val;
    logic              hazard;
    logic              issue;
    logic              cancel;
    logic              wb_reg_en;
    rrex_t             rrex_q;
    rrex_t             rrex_issue;

    rr_scoreboard #(
        .MAX_INFLIGHT(MAX_INFLIGHT)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .use_src1   (ctrl_in[CTRL_USE_SRC1]),
        .use_src2   (ctrl_in[CTRL_USE_SRC2]),
        .reg_write  (ctrl_in[CTRL_REG_WRITE]),
        .src1_idx   (src1_idx_in),
        .src2_idx   (src2_idx_in),
        .dst_idx    (dst_idx_in),
        .inc_en     (issue && ctrl_in[CTRL_REG_WRITE]),
        .inc_idx    (dst_idx_in),
        .wb_valid   (wb_valid),
        .wb_idx     (wb_idx),
        .cancel     (cancel),
        .cancel_idx (rrex_q.dst),
        .hazard     (hazard)
    );

    assign stall_out = stall_in || hazard;
    assign issue     = valid_in && !hazard && !stall_in && !flush;
    // A writer stuck in RR/EX that gets flushed will never write back.
    assign cancel    = flush && stall_in && rrex_q.valid && rrex_q.ctrl[CTRL_REG_WRITE];

`ifdef RR_R0_ZERO_EN
    assign wb_reg_en = wb_valid && (wb_idx != '0);
`else
    assign wb_reg_en = wb_valid;
`endif

    // Operand read with same-cycle writeback bypass.
    always_comb begin
        src1_val = regs[src1_idx_in];
        src2_val = regs[src2_idx_in];
        if (wb_reg_en && wb_idx == src1_idx_in) src1_val = wb_data;
        if (wb_reg_en && wb_idx == src2_idx_in) src2_val = wb_data;
`ifdef RR_R0_ZERO_EN
        if (src1_idx_in == '0) src1_val = '0;
        if (src2_idx_in == '0) src2_val = '0;
`endif
    end

    always_comb begin
        rrex_issue          = '0;
        rrex_issue.valid    = 1'b1;
        rrex_issue.pc       = pc_in;
        rrex_issue.len      = instr_length_in;
        rrex_issue.ctrl     = ctrl_in;
        rrex_issue.dst      = dst_idx_in;
        rrex_issue.imm      = imm_in;
        rrex_issue.src1_val = src1_val;
        rrex_issue.src2_val = src2_val;
    end

    // Register file: writebacks apply regardless of stall or flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
        end else if (wb_reg_en) begin
            regs[wb_idx] <= wb_data;
        end
    end

    // RR/EX register: flush clears, stall_in holds, otherwise issue or bubble.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rrex_q <= '0;
        end else if (!stall_in) begin
            rrex_q <= issue ? rrex_issue : '0;
        end
    end

    assign valid_out        = rrex_q.valid;
    assign pc_out           = rrex_q.pc;
    assign instr_length_out = rrex_q.len;
    assign ctrl_out         = rrex_q.ctrl;
    assign dst_idx_out      = rrex_q.dst;
    assign imm_out          = rrex_q.imm;
    assign src1_val_out     = rrex_q.src1_val;
    assign src2_val_out     = rrex_q.src2_val;

endmodule

// File: tb/tb_rr_stage.sv
// Self-checking bench for rr_stage: directed vector table with hand-derived
// expectations, then randomized traffic checked against a reference model.
module tb_rr_stage;

    localparam int MAXF  = 3;
    localparam int OUT_W = 142;
`ifdef RR_R0_ZERO_EN
    localparam bit R0Z = 1'b1;
`else
    localparam bit R0Z = 1'b0;
`endif

    localparam logic [6:0] C_WR = 7'h01;
    localparam logic [6:0] C_S1 = 7'h02;
    localparam logic [6:0] C_S2 = 7'h04;

    // ---------------- DUT signals ----------------
    logic        clk;
    logic        rst, stall_in, flush, valid_in;
    logic [31:0] pc_in, imm_in, wb_data;
    logic [2:0]  instr_length_in, dst_idx_in, src1_idx_in, src2_idx_in, wb_idx;
    logic [6:0]  ctrl_in;
    logic        wb_valid;
    logic        stall_out, valid_out;
    logic [31:0] pc_out, imm_out, src1_val_out, src2_val_out;
    logic [2:0]  instr_length_out, dst_idx_out;
    logic [6:0]  ctrl_out;

    rr_stage #(.MAX_INFLIGHT(MAXF)) dut (
        .clk(clk), .rst(rst), .stall_in(stall_in), .flush(flush),
        .valid_in(valid_in), .pc_in(pc_in), .instr_length_in(instr_length_in),
        .ctrl_in(ctrl_in), .dst_idx_in(dst_idx_in), .src1_idx_in(src1_idx_in),
        .src2_idx_in(src2_idx_in), .imm_in(imm_in), .wb_valid(wb_valid),
        .wb_idx(wb_idx), .wb_data(wb_data), .stall_out(stall_out),
        .valid_out(valid_out), .pc_out(pc_out), .instr_length_out(instr_length_out),
        .ctrl_out(ctrl_out), .dst_idx_out(dst_idx_out), .imm_out(imm_out),
        .src1_val_out(src1_val_out), .src2_val_out(src2_val_out)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- vectors ----------------
    typedef struct {
        bit          rst, stl, fl, v;
        logic [31:0] pc;
        logic [6:0]  ctrl;
        logic [2:0]  dst, s1, s2;
        bit          wbv;
        logic [2:0]  wbi;
        logic [31:0] wbd;
        bit          e_stall, e_valid;
        logic [31:0] e_pc, e_s1, e_s2;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit r, bit stl, bit fl, bit v, logic [31:0] pc,
                                logic [6:0] ctrl, logic [2:0] dst, logic [2:0] s1,
                                logic [2:0] s2, bit wbv, logic [2:0] wbi,
                                logic [31:0] wbd, bit es, bit ev, logic [31:0] epc,
                                logic [31:0] es1, logic [31:0] es2);
        vec_t t;
        t.rst = r; t.stl = stl; t.fl = fl; t.v = v; t.pc = pc; t.ctrl = ctrl;
        t.dst = dst; t.s1 = s1; t.s2 = s2; t.wbv = wbv; t.wbi = wbi; t.wbd = wbd;
        t.e_stall = es; t.e_valid = ev; t.e_pc = epc; t.e_s1 = es1; t.e_s2 = es2;
        return t;
    endfunction

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [2:0]  len;
        logic [6:0]  ctrl;
        logic [2:0]  dst;
        logic [31:0] imm;
        logic [31:0] s1;
        logic [31:0] s2;
    } out_t;

    logic [31:0]      m_regs [8];
    int               m_pend [8];
    out_t             m_out;
    logic [31:0]      n_regs [8];
    int               n_pend [8];
    out_t             n_out;
    bit               m_stall;
    logic [OUT_W-1:0] exp_q[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Outstanding writes to r as seen by an instruction this cycle.
    function automatic int eff(input logic [2:0] r);
        int p;
        if (R0Z && r == 3'd0) return 0;
        p = m_pend[r];
        if (wb_valid && wb_idx == r && p > 0) p = p - 1;
        return p;
    endfunction

    function automatic logic [31:0] operand(input logic [2:0] r);
        if (R0Z && r == 3'd0) return 32'h0;
        if (wb_valid && wb_idx == r) return wb_data;
        return m_regs[r];
    endfunction

    task automatic model_eval();
        bit hz, iss, canc;
        hz = valid_in && ((ctrl_in[1] && eff(src1_idx_in) > 0) ||
                          (ctrl_in[2] && eff(src2_idx_in) > 0) ||
                          (ctrl_in[0] && eff(dst_idx_in) == MAXF));
        m_stall = stall_in || hz;
        n_regs = m_regs;
        n_pend = m_pend;
        if (rst) begin
            for (int r = 0; r < 8; r++) begin
                n_regs[r] = '0;
                n_pend[r] = 0;
            end
            n_out = '0;
        end else begin
            iss  = valid_in && !hz && !stall_in && !flush;
            canc = flush && stall_in && m_out.v && m_out.ctrl[0];
            if (iss && ctrl_in[0] && !(R0Z && dst_idx_in == 3'd0))
                n_pend[dst_idx_in] = n_pend[dst_idx_in] + 1;
            if (wb_valid && n_pend[wb_idx] > 0)
                n_pend[wb_idx] = n_pend[wb_idx] - 1;
            if (canc && n_pend[m_out.dst] > 0)
                n_pend[m_out.dst] = n_pend[m_out.dst] - 1;
            if (wb_valid && !(R0Z && wb_idx == 3'd0))
                n_regs[wb_idx] = wb_data;
            if (flush)
                n_out = '0;
            else if (stall_in)
                n_out = m_out;
            else if (iss)
                n_out = '{v: 1'b1, pc: pc_in, len: instr_length_in, ctrl: ctrl_in,
                          dst: dst_idx_in, imm: imm_in,
                          s1: operand(src1_idx_in), s2: operand(src2_idx_in)};
            else
                n_out = '0;
        end
        exp_q.push_back(n_out);
    endtask

    // ---------------- driver tasks ----------------
    task automatic apply(input vec_t t, input logic [2:0] len, input logic [31:0] imm);
        @(negedge clk);
        rst = t.rst; stall_in = t.stl; flush = t.fl; valid_in = t.v;
        pc_in = t.pc; ctrl_in = t.ctrl; dst_idx_in = t.dst;
        src1_idx_in = t.s1; src2_idx_in = t.s2;
        wb_valid = t.wbv; wb_idx = t.wbi; wb_data = t.wbd;
        instr_length_in = len; imm_in = imm;
        #1;
        model_eval();
        check("stall_model", {159'b0, stall_out}, {159'b0, m_stall});
    endtask

    task automatic tick();
        logic [OUT_W-1:0] exp_v;
        @(posedge clk);
        m_regs = n_regs;
        m_pend = n_pend;
        m_out  = n_out;
        #1;
        exp_v = exp_q.pop_front();
        check("rrex_model",
              {18'b0, valid_out, pc_out, instr_length_out, ctrl_out, dst_idx_out,
               imm_out, src1_val_out, src2_val_out},
              {18'b0, exp_v});
    endtask

    // ---------------- test ----------------
    initial begin
        vec_t t;
        rst = 1'b1; stall_in = 0; flush = 0; valid_in = 0; pc_in = 0;
        ctrl_in = 0; dst_idx_in = 0; src1_idx_in = 0; src2_idx_in = 0;
        imm_in = 0; instr_length_in = 0; wb_valid = 0; wb_idx = 0; wb_data = 0;
        for (int r = 0; r < 8; r++) begin
            m_regs[r] = '0;
            m_pend[r] = 0;
        end
        m_out = '0;

        //                 rst stl fl v  pc            ctrl       dst s1 s2  wbv wbi wbd            es ev e_pc          e_s1      e_s2
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,        7'h0,      0, 0, 0,  0, 0, 32'h0,         0, 0, 32'h0,        32'h0,    32'h0));
        vecs.push_back(mk(1, 0, 1, 1, 32'h77,       C_WR|C_S1, 5, 1, 2,  0, 0, 32'h0,         0, 0, 32'h0,        32'h0,    32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        7'h0,      0, 0, 0,  1, 1, 32'h11,        0, 0, 32'h0,        32'h0,    32'h0));
        vecs.push_back(mk(0, 0, 0, 1, 32'h100,      C_S1,      0, 1, 0,  0, 0, 32'h0,         0, 1, 32'h100,      32'h11,   32'h0));
        vecs.push_back(mk(0, 0, 0, 1, 32'h104,      C_WR,      2, 0, 0,  0, 0, 32'h0,         0, 1, 32'h104,      32'h0,    32'h0));
        vecs.push_back(mk(0, 0, 0, 1, 32'h108,      C_S2,      0, 0, 2,  0, 0, 32'h0,         1, 0, 32'h0,        32'h0,    32'h0));
        vecs.push_back(mk(0, 0, 0, 1, 32'h108,      C_S2,      0, 0, 2,  1, 2, 32'hAB,        0, 1, 32'h108,      32'h0,    32'hAB));
        vecs.push_back(mk(0, 0, 0, 1, 32'h200,      C_WR,      3, 0, 0,  0, 0, 32'h0,         0, 1, 32'h200,      32'h0,    32'h0));
        vecs.push_back(mk(0, 0, 0, 1, 32'h204,      C_WR,      3, 0, 0,  0, 0, 32'h0,         0, 1, 32'h204,      32'h0,    32'h0));
        vecs.push_back(mk(0, 0, 0, 1, 32'h208,      C_WR,      3, 0, 0,  0, 0, 32'h0,         0, 1, 32'h208,      32'h0,    32'h0));
        vecs.push_back(mk(0, 0, 0, 1, 32'h20C,      C_WR,      3, 0, 0,  0, 0, 32'h0,         1, 0, 32'h0,        32'h0,    32'h0));
        vecs.push_back(mk(0, 0, 0, 1, 32'h20C,      C_WR,      3, 0, 0,  1, 3, 32'h33,        0, 1, 32'h20C,      32'h0,    32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        7'h0,      0, 0, 0,  1, 3, 32'h33,        0, 0, 32'h0,        32'h0,    32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        7'h0,      0, 0, 0,  1, 3, 32'h33,        0, 0, 32'h0,        32'h0,    32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        7'h0,      0, 0, 0,  1, 3, 32'h33,        0, 0, 32'h0,        32'h0,    32'h0));
        vecs.push_back(mk(0, 0, 0, 1, 32'h300,      C_WR|C_S1, 4, 1, 0,  0, 0, 32'h0,         0, 1, 32'h300,      32'h11,   32'h0));
        vecs.push_back(mk(0, 1, 0, 1, 32'hDEADBEEF, C_S1,      0, 1, 0,  0, 0, 32'h0,         1, 1, 32'h300,      32'h11,   32'h0));
        vecs.push_back(mk(0, 1, 1, 1, 32'hDEADBEEF, C_S1,      0, 1, 0,  0, 0, 32'h0,         1, 0, 32'h0,        32'h0,    32'h0));
        vecs.push_back(mk(0, 0, 0, 1, 32'h400,      C_S1|C_S2, 0, 4, 4,  0, 0, 32'h0,         0, 1, 32'h400,      32'h0,    32'h0));
        vecs.push_back(mk(0, 0, 1, 1, 32'h500,      C_WR,      5, 0, 0,  0, 0, 32'h0,         0, 0, 32'h0,        32'h0,    32'h0));
        vecs.push_back(mk(0, 0, 0, 1, 32'h504,      C_S1,      0, 5, 0,  0, 0, 32'h0,         0, 1, 32'h504,      32'h0,    32'h0));

        for (int i = 0; i < vecs.size(); i++) begin
            t = vecs[i];
            apply(t, 3'd4, t.pc ^ 32'h5A5A0000);
            check($sformatf("v%0d_stall", i), {159'b0, stall_out}, {159'b0, t.e_stall});
            tick();
            check($sformatf("v%0d_valid", i), {159'b0, valid_out}, {159'b0, t.e_valid});
            check($sformatf("v%0d_pc", i), {128'b0, pc_out}, {128'b0, t.e_pc});
            check($sformatf("v%0d_src1", i), {128'b0, src1_val_out}, {128'b0, t.e_s1});
            check($sformatf("v%0d_src2", i), {128'b0, src2_val_out}, {128'b0, t.e_s2});
        end

        // Randomized traffic against the reference model.
        for (int n = 0; n < 500; n++) begin
            t = mk(0, ($urandom_range(0, 7) == 0), ($urandom_range(0, 11) == 0),
                   ($urandom_range(0, 3) != 0), $urandom, 7'($urandom_range(0, 127)),
                   3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                   3'($urandom_range(0, 7)), ($urandom_range(0, 1) == 1),
                   3'($urandom_range(0, 7)), $urandom, 0, 0, 0, 0, 0);
            apply(t, 3'($urandom_range(0, 7)), $urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
